// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - round/timeout game controller with optional time-bonus score (ROUND_CTRL_SCORE_EN)
// With ROUND_CTRL_SCORE_EN undefined, the score output is tied to zero.
module round_ctrl #(
  parameter int MAX_ROUND = 10
) (
  input  logic       clkt,
  input  logic       R,
  input  logic       enter,
  input  logic       match,
  input  logic [3:0] tempo,
  input  logic       end_time,
  output logic       R_time,
  output logic       E_time,
  output logic [3:0] round,
  output logic [7:0] score,
  output logic       end_game,
  output logic       win,
  output logic [2:0] state
);

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] PLAY   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;
  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUND - 1);

  logic [2:0] cur;
  logic       enter_d;
  logic       armed;
  logic       enter_rise;

  // armed stays low for the first edge after reset so a button already held
  // down when reset is released is not mistaken for a new press.
  assign enter_rise = enter & ~enter_d & armed;

  assign state  = cur;
  assign R_time = (cur == INIT) || (cur == SETUP) || (cur == RESULT);
  assign E_time = (cur == PLAY);

  always_ff @(posedge clkt or posedge R) begin
    if (R) begin
      cur      <= INIT;
      round    <= 4'd0;
      win      <= 1'b0;
      end_game <= 1'b0;
      enter_d  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      enter_d <= enter;
      armed   <= 1'b1;
      case (cur)
        INIT: begin
          if (enter_rise) cur <= SETUP;
        end
        SETUP: begin
          cur <= PLAY;
        end
        PLAY: begin
          if (end_time) begin
            cur      <= RESULT;
            win      <= 1'b0;
            end_game <= 1'b1;
          end else if (enter_rise) begin
            cur <= CHECK;
          end
        end
        CHECK: begin
          if (!match) begin
            cur      <= RESULT;
            win      <= 1'b0;
            end_game <= 1'b1;
          end else if (round == LAST_ROUND) begin
            cur      <= RESULT;
            win      <= 1'b1;
            end_game <= 1'b1;
          end else begin
            round <= round + 4'd1;
            cur   <= SETUP;
          end
        end
        RESULT: begin
          if (enter_rise) begin
            cur      <= INIT;
            round    <= 4'd0;
            win      <= 1'b0;
            end_game <= 1'b0;
          end
        end
        default: begin
          cur      <= INIT;
          round    <= 4'd0;
          win      <= 1'b0;
          end_game <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROUND_CTRL_SCORE_EN
  logic [3:0] t_hold;
  logic [3:0] bonus;
  logic [8:0] sum;

  // Faster confirmation earns more; out-of-range tempo values earn nothing.
  assign bonus = (t_hold > 4'd9) ? 4'd0 : (4'd9 - t_hold);
  assign sum   = {1'b0, score} + {5'd0, bonus};

  always_ff @(posedge clkt or posedge R) begin
    if (R) begin
      t_hold <= 4'd0;
      score  <= 8'd0;
    end else begin
      if (cur == PLAY && !end_time && enter_rise) t_hold <= tempo;
      if (cur == INIT && enter_rise) begin
        score <= 8'd0;
      end else if (cur == CHECK && match) begin
        score <= sum[8] ? 8'hFF : sum[7:0];
      end
    end
  end
`else
  logic unused_tempo;
  assign unused_tempo = ^tempo;
  assign score        = 8'd0;
`endif

endmodule
